// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and external memory bus signals of the shared memory port.
// slave = arbiter view, master = core fetch/dmem units plus external memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wstrb;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            d_err;

    logic            ext_ren;
    logic            ext_wen;
    logic [AW-1:0]   ext_addr;
    logic [DW-1:0]   ext_wdata;
    logic [DW/8-1:0] ext_wstrb;
    logic            ext_valid;
    logic [DW-1:0]   ext_rdata;
    logic            busy;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output ext_ren, ext_wen, ext_addr, ext_wdata, ext_wstrb,
        input  ext_valid, ext_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  ext_ren, ext_wen, ext_addr, ext_wdata, ext_wstrb,
        output ext_valid, ext_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// One-at-a-time arbiter of the external memory port between fetch and data, data-priority with fetch anti-starvation.
// Latency: gnt->rvalid >= 2 cycles (timeout TIMEOUT+2); backpressure: requests wait for gnt, none granted while busy.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] wstrb;
    } ext_req_t;

    state_t        state_q, state_d;
    ext_req_t      ext_req_q, ext_req_d;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_i, grant_d;
    logic          starved, tmo_hit, done;
    logic          ext_ren_q, ext_wen_q;
    logic          i_rvalid_q, i_err_q, d_rvalid_q, d_err_q;
    logic [DW-1:0] i_rdata_q, d_rdata_q;

    assign starved = (starve_cnt == SW'(STARVE_MAX));
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT));
    assign done    = (state_q != IDLE) && (bus.ext_valid || tmo_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        state_d   = state_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        ext_req_d = '0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (bus.i_req && (!bus.d_req || starved)) begin
                        grant_i = 1'b1;
                        state_d = BUSY_I;
                    end else if (bus.d_req) begin
                        grant_d = 1'b1;
                        state_d = BUSY_D;
                    end
                end
                ext_req_d.addr  = grant_d ? bus.d_addr : bus.i_addr;
                ext_req_d.wdata = grant_d ? bus.d_wdata : '0;
                ext_req_d.wstrb = (grant_d && bus.d_we) ? bus.d_wstrb : '0;
            end
            BUSY_I, BUSY_D: begin
                if (bus.ext_valid || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_req_q  <= '0;
            ext_ren_q  <= 1'b0;
            ext_wen_q  <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            if (grant_i || grant_d) begin
                ext_req_q <= ext_req_d;
                ext_ren_q <= grant_i || !bus.d_we;
                ext_wen_q <= grant_d && bus.d_we;
                tmo_cnt   <= '0;
                if (grant_d && bus.i_req)
                    starve_cnt <= starved ? starve_cnt : starve_cnt + SW'(1);
                else
                    starve_cnt <= '0;
            end else if (state_q != IDLE) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                // ext_valid outranks a coincident timeout.
                if (done) begin
                    ext_ren_q <= 1'b0;
                    ext_wen_q <= 1'b0;
                    if (state_q == BUSY_I) begin
                        i_rvalid_q <= 1'b1;
                        i_err_q    <= !bus.ext_valid;
                        i_rdata_q  <= bus.ext_valid ? bus.ext_rdata : '0;
                    end else begin
                        d_rvalid_q <= 1'b1;
                        d_err_q    <= !bus.ext_valid;
                        d_rdata_q  <= (bus.ext_valid && ext_ren_q) ? bus.ext_rdata : '0;
                    end
                end
            end
        end
    end

    assign bus.i_gnt     = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ext_ren   = ext_ren_q;
    assign bus.ext_wen   = ext_wen_q;
    assign bus.ext_addr  = ext_req_q.addr;
    assign bus.ext_wdata = ext_req_q.wdata;
    assign bus.ext_wstrb = ext_req_q.wstrb;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.i_err     = i_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 255;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    int   ext_lat;
    bit   ext_force;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Grant log written from observed DUT grants
    byte glog_who[$];
    int  glog_cyc[$];

    task automatic wait_grants(input int n, input int budget);
        int k;
        k = 0;
        while (glog_who.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("grant_wait", glog_who.size() >= n, 1);
    endtask

    // Transaction-level model: one outstanding access and one pending response
    bit          m_busy, m_d, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_start, wins, rsp_cyc;
    bit          rsp_d, rsp_err;
    logic [31:0] rsp_dat;
    bit          e_ig, e_dg, e_irv, e_drv;

    initial begin
        m_busy = 0; rsp_cyc = -1; wins = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctl", {bus.i_gnt, bus.i_rvalid, bus.i_err, bus.d_gnt, bus.d_rvalid,
                                bus.d_err, bus.ext_ren, bus.ext_wen, bus.busy}, 0);
                chk("rst_ext", {bus.ext_addr, bus.ext_wdata}, 0);
                chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
                chk("rst_wstrb", bus.ext_wstrb, 0);
                m_busy = 0; rsp_cyc = -1; wins = 0;
            end else begin
                e_ig  = !m_busy && bus.i_req && (!bus.d_req || wins == STARVE_MAX);
                e_dg  = !m_busy && bus.d_req && !e_ig;
                e_irv = (rsp_cyc == cyc) && !rsp_d;
                e_drv = (rsp_cyc == cyc) && rsp_d;
                chk("i_gnt", bus.i_gnt, e_ig);
                chk("d_gnt", bus.d_gnt, e_dg);
                chk("busy", bus.busy, m_busy);
                chk("ext_ren", bus.ext_ren, m_busy && !m_we);
                chk("ext_wen", bus.ext_wen, m_busy && m_we);
                chk("i_rvalid", bus.i_rvalid, e_irv);
                chk("d_rvalid", bus.d_rvalid, e_drv);
                if (m_busy) begin
                    chk("ext_addr", bus.ext_addr, m_addr);
                    chk("ext_wstrb", bus.ext_wstrb, m_wstrb);
                    if (m_d) chk("ext_wdata", bus.ext_wdata, m_wdata);
                end
                if (e_irv) begin
                    chk("i_rdata", bus.i_rdata, rsp_dat);
                    chk("i_err", bus.i_err, rsp_err);
                end
                if (e_drv) begin
                    chk("d_rdata", bus.d_rdata, rsp_dat);
                    chk("d_err", bus.d_err, rsp_err);
                end
                if (bus.i_gnt) begin glog_who.push_back("I"); glog_cyc.push_back(cyc); end
                if (bus.d_gnt) begin glog_who.push_back("D"); glog_cyc.push_back(cyc); end
                // Advance the model across the coming clock edge
                if (m_busy) begin
                    if (bus.ext_valid || (cyc - m_start) == TIMEOUT + 1) begin
                        rsp_cyc = cyc + 1;
                        rsp_d   = m_d;
                        rsp_err = !bus.ext_valid;
                        rsp_dat = (bus.ext_valid && !m_we) ? bus.ext_rdata : 32'h0;
                        m_busy  = 0;
                    end
                end else if (e_ig || e_dg) begin
                    m_busy  = 1;
                    m_start = cyc;
                    m_d     = e_dg;
                    m_we    = e_dg && bus.d_we;
                    m_addr  = e_dg ? bus.d_addr : bus.i_addr;
                    m_wdata = bus.d_wdata;
                    m_wstrb = m_we ? bus.d_wstrb : 4'h0;
                    if (e_dg && bus.i_req) wins = (wins < STARVE_MAX) ? wins + 1 : STARVE_MAX;
                    else                   wins = 0;
                end
            end
        end
    end

    // External memory: completes after ext_lat strobe cycles (0 = never)
    initial begin
        int cnt;
        cnt = 0;
        bus.ext_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.ext_ren || bus.ext_wen) cnt++;
            else                            cnt = 0;
            bus.ext_valid = ext_force || (ext_lat != 0 && cnt == ext_lat);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        string order;
        int    nren;
        rst = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0;
        bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0; bus.ext_rdata = 32'h0;
        ext_lat = 1; ext_force = 0;

        // Reset: no grants despite requests
        mid();
        chk("reset_i_gnt", bus.i_gnt, 0);
        chk("reset_d_gnt", bus.d_gnt, 0);
        chk("reset_busy", bus.busy, 0);
        step();
        bus.i_req = 1'b0; bus.d_req = 1'b0; rst = 1'b0;
        step();

        // Lone fetch, ext_valid on third strobe cycle
        bus.i_req = 1'b1; bus.i_addr = 32'h100; ext_lat = 3; bus.ext_rdata = 32'h13;
        mid(); chk("fetch_gnt", bus.i_gnt, 1);
        step(); bus.i_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            mid(); chk("fetch_ren", bus.ext_ren, 1); chk("fetch_addr", bus.ext_addr, 32'h100);
            step();
        end
        mid();
        chk("fetch_rvalid", bus.i_rvalid, 1);
        chk("fetch_rdata", bus.i_rdata, 32'h13);
        chk("fetch_err", bus.i_err, 0);
        step();

        // Data write, one-cycle completion
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'hF; ext_lat = 1; bus.ext_rdata = 32'hCAFEF00D;
        mid(); chk("wr_gnt", bus.d_gnt, 1);
        step(); bus.d_req = 1'b0;
        mid();
        chk("wr_wen", bus.ext_wen, 1); chk("wr_ren", bus.ext_ren, 0);
        chk("wr_wdata", bus.ext_wdata, 32'hDEADBEEF); chk("wr_wstrb", bus.ext_wstrb, 4'hF);
        step();
        mid();
        chk("wr_rvalid", bus.d_rvalid, 1); chk("wr_rdata", bus.d_rdata, 0); chk("wr_wen_low", bus.ext_wen, 0);
        step();

        // ext_valid while idle is ignored
        ext_force = 1; step(); ext_force = 0;
        mid(); chk("idle_ev_i", bus.i_rvalid, 0); chk("idle_ev_d", bus.d_rvalid, 0);
        step();

        // Both requesting continuously: starvation pattern
        glog_who.delete(); glog_cyc.delete();
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400; bus.ext_rdata = 32'h12345678;
        wait_grants(10, 40);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        order = "DDDDIDDDDI";
        for (int i = 0; i < 10; i++) chk("starve_order", glog_who[i], order[i]);
        for (int i = 1; i < 10; i++) chk("starve_spacing", glog_cyc[i] - glog_cyc[i-1], 2);
        repeat (3) step();

        // Fetch timeout with data waiting behind it
        bus.i_req = 1'b1; bus.i_addr = 32'h700; ext_lat = 0;
        mid(); chk("to_gnt", bus.i_gnt, 1);
        step(); bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
        nren = 0;
        for (int k = 1; k <= 256; k++) begin
            mid(); if (bus.ext_ren) nren++;
            step();
        end
        chk("to_ren_cycles", nren, 256);
        mid();
        chk("to_rvalid", bus.i_rvalid, 1); chk("to_err", bus.i_err, 1);
        chk("to_rdata", bus.i_rdata, 0); chk("to_dgnt", bus.d_gnt, 1);
        step(); bus.d_req = 1'b0; ext_lat = 2; bus.ext_rdata = 32'hA5A5A5A5;
        repeat (4) step();

        // ext_valid coincides with the timeout cycle
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h900;
        ext_lat = TIMEOUT + 1; bus.ext_rdata = 32'h55;
        mid(); chk("co_gnt", bus.d_gnt, 1);
        step(); bus.d_req = 1'b0;
        repeat (256) step();
        mid();
        chk("co_rvalid", bus.d_rvalid, 1); chk("co_err", bus.d_err, 0); chk("co_rdata", bus.d_rdata, 32'h55);
        step();

        // Reset during BUSY_D with starvation count at its limit
        glog_who.delete(); glog_cyc.delete();
        ext_lat = 1;
        bus.i_req = 1'b1; bus.i_addr = 32'hA00;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hB00;
        wait_grants(4, 20);
        ext_lat = 0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst_ren", bus.ext_ren, 0); chk("arst_busy", bus.busy, 0);
        chk("arst_dgnt", bus.d_gnt, 0); chk("arst_igut", bus.i_gnt, 0);
        glog_who.delete(); glog_cyc.delete();
        step(); rst = 1'b0; ext_lat = 1;
        mid(); chk("post_rst_dgnt", bus.d_gnt, 1); chk("post_rst_igut", bus.i_gnt, 0);
        wait_grants(5, 20);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        order = "DDDDI";
        for (int i = 0; i < 5; i++) chk("post_rst_order", glog_who[i], order[i]);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
